// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// ---------------
// Memory-stage access controller. Latches one load/store from the memory
// stage, drives it on the data bus (held stable until data_ok), aligns and
// sign/zero-extends load data, and hands exactly one response per operation
// to writeback over a valid/ready handshake. Misaligned loads are answered
// locally with load_misalign=1 and never reach the bus. A flush drops the
// pending response; a flushed bus transaction is drained to completion
// because the bus cannot abandon it.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_*                      memory-stage request and req_ready stall
//   flush                      kill in-flight/pending operation
//   dbus_valid/addr/size/strobe/data   registered bus request
//   dbus_addr_ok, dbus_data_ok, dbus_rdata   bus completion and load data
//   resp_valid/ready/data, load_misalign     writeback handshake
module mem_access_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2:0]          req_size,
    input  logic                req_unsigned,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strobe,
    output logic                req_ready,
    input  logic                flush,
    output logic                dbus_valid,
    output logic [ADDR_W-1:0]   dbus_addr,
    output logic [2:0]          dbus_size,
    output logic [DATA_W/8-1:0] dbus_strobe,
    output logic [DATA_W-1:0]   dbus_data,
    input  logic                dbus_addr_ok,
    input  logic                dbus_data_ok,
    input  logic [DATA_W-1:0]   dbus_rdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_data,
    output logic                load_misalign
);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

    state_t                state_q;
    logic                  dbus_valid_q;
    logic [ADDR_W-1:0]     dbus_addr_q;
    logic [2:0]            dbus_size_q;
    logic [DATA_W/8-1:0]   dbus_strobe_q;
    logic [DATA_W-1:0]     dbus_data_q;
    logic                  op_write_q;
    logic                  op_unsigned_q;
    logic                  resp_valid_q;
    logic [DATA_W-1:0]     resp_data_q;
    logic                  load_misalign_q;

    logic                  accept;
    logic                  misalign;
    logic [DATA_W-1:0]     shifted;
    logic                  sign_bit;
    logic [DATA_W-1:0]     load_data_d;

    // addr_ok is informational only: the request is held until data_ok
    // regardless of whether the address phase has been acknowledged.
    logic unused_addr_ok;
    assign unused_addr_ok = dbus_addr_ok;

    // A new op can enter while idle, or in the same cycle the current
    // response is consumed (zero-bubble back-to-back).
    assign req_ready = !flush && ((state_q == IDLE) || ((state_q == DONE) && resp_ready));
    assign accept    = req_valid && req_ready;

    always_comb begin
        misalign = 1'b0;
        case (req_size)
            3'd1:    misalign = req_addr[0] != 1'b0;
            3'd2:    misalign = req_addr[1:0] != 2'b00;
            3'd3:    misalign = req_addr[2:0] != 3'b000;
            default: misalign = 1'b0;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend from the
    // operand's top bit. Dword accesses are aligned, so they pass through.
    assign shifted = dbus_rdata >> {dbus_addr_q[2:0], 3'b000};

    always_comb begin
        sign_bit    = 1'b0;
        load_data_d = shifted;
        case (dbus_size_q)
            3'd0: begin
                sign_bit    = !op_unsigned_q && shifted[7];
                load_data_d = {{(DATA_W-8){sign_bit}}, shifted[7:0]};
            end
            3'd1: begin
                sign_bit    = !op_unsigned_q && shifted[15];
                load_data_d = {{(DATA_W-16){sign_bit}}, shifted[15:0]};
            end
            3'd2: begin
                sign_bit    = !op_unsigned_q && shifted[31];
                load_data_d = {{(DATA_W-32){sign_bit}}, shifted[31:0]};
            end
            default: load_data_d = shifted;
        endcase
        if (op_write_q) begin
            load_data_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            dbus_valid_q    <= 1'b0;
            dbus_addr_q     <= '0;
            dbus_size_q     <= '0;
            dbus_strobe_q   <= '0;
            dbus_data_q     <= '0;
            op_write_q      <= 1'b0;
            op_unsigned_q   <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            load_misalign_q <= 1'b0;
        end else begin
            case (state_q)
                BUSY: begin
                    if (dbus_data_ok) begin
                        dbus_valid_q <= 1'b0;
                        if (flush) begin
                            state_q <= IDLE;
                        end else begin
                            state_q         <= DONE;
                            resp_valid_q    <= 1'b1;
                            resp_data_q     <= load_data_d;
                            load_misalign_q <= 1'b0;
                        end
                    end else if (flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dbus_data_ok) begin
                        dbus_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                DONE: begin
                    if (flush || resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: ;
            endcase

            // Accept only happens in IDLE or in a consuming DONE cycle, so
            // these assignments take priority over the DONE exit above.
            if (accept) begin
                if (!req_write && misalign) begin
                    state_q         <= DONE;
                    resp_valid_q    <= 1'b1;
                    resp_data_q     <= '0;
                    load_misalign_q <= 1'b1;
                end else begin
                    state_q       <= BUSY;
                    dbus_valid_q  <= 1'b1;
                    dbus_addr_q   <= req_addr;
                    dbus_size_q   <= req_size;
                    dbus_strobe_q <= req_write ? req_strobe : '0;
                    dbus_data_q   <= req_wdata;
                    op_write_q    <= req_write;
                    op_unsigned_q <= req_unsigned;
                end
            end
        end
    end

    assign dbus_valid    = dbus_valid_q;
    assign dbus_addr     = dbus_addr_q;
    assign dbus_size     = dbus_size_q;
    assign dbus_strobe   = dbus_strobe_q;
    assign dbus_data     = dbus_data_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign load_misalign = load_misalign_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// ------------------
// Directed vectors followed by randomized traffic. A reference model,
// updated each negative edge from the handshakes about to happen, pushes
// expected responses into a queue; the same process pops and compares them
// when the DUT presents a response. A separate bus responder answers
// requests after a configurable or random delay.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_unsigned, req_ready, flush;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic [7:0]  req_strobe;
    logic        dbus_valid, dbus_addr_ok, dbus_data_ok;
    logic [63:0] dbus_addr, dbus_data, dbus_rdata;
    logic [2:0]  dbus_size;
    logic [7:0]  dbus_strobe;
    logic        resp_valid, resp_ready, load_misalign;
    logic [63:0] resp_data;

    mem_access_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .req_strobe(req_strobe), .req_ready(req_ready), .flush(flush),
        .dbus_valid(dbus_valid), .dbus_addr(dbus_addr), .dbus_size(dbus_size),
        .dbus_strobe(dbus_strobe), .dbus_data(dbus_data),
        .dbus_addr_ok(dbus_addr_ok), .dbus_data_ok(dbus_data_ok), .dbus_rdata(dbus_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .load_misalign(load_misalign)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (specification rules) ----------------
    function automatic bit ref_misaligned(input logic [63:0] a, input logic [2:0] sz);
        int nb;
        if (sz > 3'd3) return 1'b0;
        nb = 1 << sz;
        return (a % nb) != 0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] raw, input logic [2:0] off,
                                             input logic [2:0] sz, input logic uns);
        int          nb;
        logic [63:0] v, mask;
        nb   = (sz >= 3'd3) ? 8 : (1 << sz);
        v    = raw >> (off * 8);
        mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nb * 8)) - 64'd1);
        v    = v & mask;
        if (!uns && nb < 8 && v[nb*8-1]) v = v | ~mask;
        return v;
    endfunction

    typedef struct { logic [63:0] data; logic mis; } resp_t;
    resp_t exp_q[$];

    bit          m_bus, m_drain, m_resp;
    logic [63:0] b_addr, b_data;
    logic [2:0]  b_size;
    logic [7:0]  b_strb;
    logic        b_write, b_uns;

    initial begin
        resp_t r;
        bit    exp_rr;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_dbus_valid", {63'd0, dbus_valid}, 64'd0);
                chk("rst_dbus_addr", dbus_addr, 64'd0);
                chk("rst_dbus_strobe", {56'd0, dbus_strobe}, 64'd0);
                chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
                chk("rst_resp_data", resp_data, 64'd0);
                chk("rst_load_misalign", {63'd0, load_misalign}, 64'd0);
                m_bus = 0; m_drain = 0; m_resp = 0;
                exp_q.delete();
            end else begin
                exp_rr = !flush && ((!m_bus && !m_resp) || (m_resp && resp_ready));
                chk("req_ready", {63'd0, req_ready}, {63'd0, exp_rr});
                chk("dbus_valid", {63'd0, dbus_valid}, {63'd0, m_bus});
                if (m_bus && dbus_valid) begin
                    chk("dbus_addr", dbus_addr, b_addr);
                    chk("dbus_size", {61'd0, dbus_size}, {61'd0, b_size});
                    chk("dbus_strobe", {56'd0, dbus_strobe}, {56'd0, b_strb});
                    if (b_write) chk("dbus_data", dbus_data, b_data);
                end
                chk("resp_valid", {63'd0, resp_valid}, {63'd0, m_resp});
                if (m_resp) begin
                    if (exp_q.size() == 0) begin
                        chk("resp_queue_empty", 64'd0, 64'd1);
                    end else begin
                        r = exp_q[0];
                        if (resp_valid) begin
                            chk("resp_data", resp_data, r.data);
                            chk("load_misalign", {63'd0, load_misalign}, {63'd0, r.mis});
                        end
                        if (flush || resp_ready) begin
                            if (!flush)
                                $display("resp: data=%h misalign=%b", resp_data, load_misalign);
                            void'(exp_q.pop_front());
                        end
                    end
                    if (flush || resp_ready) m_resp = 0;
                end
                if (m_bus && dbus_data_ok) begin
                    if (!m_drain && !flush) begin
                        r.data = b_write ? 64'd0 : ref_load(dbus_rdata, b_addr[2:0], b_size, b_uns);
                        r.mis  = 1'b0;
                        exp_q.push_back(r);
                        m_resp = 1;
                    end
                    m_bus = 0; m_drain = 0;
                end else if (m_bus && flush) begin
                    m_drain = 1;
                end
                if (req_valid && exp_rr) begin
                    if (!req_write && ref_misaligned(req_addr, req_size)) begin
                        r.data = 64'd0; r.mis = 1'b1;
                        exp_q.push_back(r);
                        m_resp = 1;
                    end else begin
                        m_bus   = 1;
                        b_addr  = req_addr;  b_size = req_size;
                        b_strb  = req_write ? req_strobe : 8'h00;
                        b_data  = req_wdata; b_write = req_write; b_uns = req_unsigned;
                    end
                end
            end
        end
    end

    // ---------------- bus responder ----------------
    bit          rand_bus  = 0;
    int          bus_delay = 0;
    logic [63:0] dir_rdata = 64'd0;

    initial begin
        int wait_c = -1;
        dbus_data_ok = 0; dbus_addr_ok = 0; dbus_rdata = 64'd0;
        forever begin
            @(posedge clk); #1;
            dbus_data_ok = 0; dbus_addr_ok = 0;
            dbus_rdata = rand_bus ? {$urandom, $urandom} : dir_rdata;
            if (dbus_valid && !reset) begin
                if (wait_c < 0) wait_c = rand_bus ? int'($urandom_range(0, 3)) : bus_delay;
                if (wait_c == 0) begin
                    dbus_data_ok = 1; dbus_addr_ok = 1; wait_c = -1;
                end else begin
                    wait_c--; dbus_addr_ok = 1'($urandom % 2);
                end
            end else begin
                wait_c = -1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_op(input logic w, input logic [63:0] a, input logic [2:0] s,
                         input logic u, input logic [63:0] wd, input logic [7:0] st);
        bit got = 0;
        req_valid = 1; req_write = w; req_addr = a; req_size = s;
        req_unsigned = u; req_wdata = wd; req_strobe = st;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 0;
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_quiet();
        bit q = 0;
        for (int i = 0; i < 200 && !q; i++) begin
            @(negedge clk);
            q = !dbus_valid && !resp_valid && !m_bus && !m_resp;
        end
        if (!q) chk("quiet_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_dbus();
        bit v = 0;
        for (int i = 0; i < 50 && !v; i++) begin
            @(negedge clk);
            v = dbus_valid;
        end
        if (!v) chk("dbus_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        reset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_size = 0;
        req_unsigned = 0; req_wdata = 0; req_strobe = 0; flush = 0; resp_ready = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Byte loads, signed and unsigned.
        dir_rdata = 64'h0000_0000_8000_0000;
        do_op(0, 64'h8000_0003, 3'd0, 0, 64'd0, 8'h00); wait_quiet();
        do_op(0, 64'h8000_0003, 3'd0, 1, 64'd0, 8'h00); wait_quiet();
        // Word loads and dword pass-through.
        dir_rdata = 64'h89AB_CDEF_0000_0000;
        do_op(0, 64'h8000_0004, 3'd2, 0, 64'd0, 8'h00); wait_quiet();
        do_op(0, 64'h8000_0004, 3'd2, 1, 64'd0, 8'h00); wait_quiet();
        do_op(0, 64'h8000_0008, 3'd3, 0, 64'd0, 8'h00); wait_quiet();
        // Store with data_ok held off 3 cycles.
        bus_delay = 3;
        do_op(1, 64'h8000_0010, 3'd2, 0, 64'h1122_3344_5566_7788, 8'h0F); wait_quiet();
        // Misaligned half load: answered without a bus request.
        do_op(0, 64'h0000_1001, 3'd1, 0, 64'd0, 8'h00); wait_quiet();
        // Flush while busy: transaction drains, no response.
        bus_delay = 4;
        do_op(0, 64'h8000_0020, 3'd3, 0, 64'd0, 8'h00);
        wait_dbus();
        @(posedge clk); #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        wait_quiet();
        // Back-to-back loads, second accepted in the DONE cycle.
        bus_delay = 0;
        do_op(0, 64'h8000_0001, 3'd0, 0, 64'd0, 8'h00);
        do_op(0, 64'h8000_0006, 3'd1, 1, 64'd0, 8'h00);
        wait_quiet();
        // Writeback stalls for 2 cycles: response must be held.
        resp_ready = 0;
        do_op(0, 64'h8000_0004, 3'd2, 0, 64'd0, 8'h00);
        repeat (3) @(posedge clk);
        #1 resp_ready = 1;
        wait_quiet();
        // Reset in the middle of a bus transaction.
        bus_delay = 20;
        do_op(0, 64'h8000_0030, 3'd3, 0, 64'd0, 8'h00);
        wait_dbus();
        @(posedge clk); #2 reset = 1;
        #1;
        chk("async_rst_dbus_valid", {63'd0, dbus_valid}, 64'd0);
        chk("async_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        @(posedge clk); #1 reset = 0;
        bus_delay = 0;

        // Randomized traffic.
        rand_bus = 1;
        for (int c = 0; c < 1500; c++) begin
            logic [2:0]  s;
            logic [63:0] a;
            s = 3'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            if ($urandom % 4 != 0) a = a & ~((64'd1 << s) - 64'd1);
            req_valid    = 1'($urandom % 2);
            req_write    = 1'($urandom % 2);
            req_addr     = a;
            req_size     = s;
            req_unsigned = 1'($urandom % 2);
            req_wdata    = {$urandom, $urandom};
            req_strobe   = 8'($urandom);
            resp_ready   = ($urandom % 4) != 0;
            flush        = ($urandom % 16) == 0;
            @(posedge clk); #1;
        end
        req_valid = 0; flush = 0; resp_ready = 1;
        wait_quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
